// File: rtl/ws2811_driver.sv
// WS2811/WS2812 chain driver: latch gap, then one GRB word per LED.
// Colours are fetched per LED from an external store via address.
module ws2811_driver #(
   parameter int NUM_LEDS     = 8,
   parameter int SYSTEM_CLOCK = 100000000
) (
   input  logic                     clk,
   input  logic                     reset,
   output logic [(NUM_LEDS > 1 ? $clog2(NUM_LEDS) : 1)-1:0] address,
   input  logic [7:0]               red_in,
   input  logic [7:0]               green_in,
   input  logic [7:0]               blue_in,
   output logic                     DO
);

   localparam int AW      = NUM_LEDS > 1 ? $clog2(NUM_LEDS) : 1;
   localparam int BIT_CYC = SYSTEM_CLOCK / 800000;
   localparam int T0H_CYC = (SYSTEM_CLOCK / 20000000) * 7;
   localparam int T1H_CYC = (SYSTEM_CLOCK / 10000000) * 7;
   localparam int RST_CYC = SYSTEM_CLOCK / 20000;
   localparam int MAX_CYC = RST_CYC > BIT_CYC ? RST_CYC : BIT_CYC;
   localparam int CW      = $clog2(MAX_CYC + 1);

   typedef enum logic [1:0] {
      LATCHGAP,
      LOAD,
      SEND
   } state_t;

   state_t          state;
   state_t          state_nx;
   logic [CW-1:0]   cyc;
   logic [CW-1:0]   cyc_nx;
   logic [4:0]      bitn;
   logic [4:0]      bitn_nx;
   logic [23:0]     shreg;
   logic [23:0]     shreg_nx;
   logic [AW-1:0]   addr_nx;
   logic            do_nx;
   logic [CW-1:0]   hi_cyc;

   // State, datapath and the registered serial output
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= LATCHGAP;
         cyc     <= '0;
         bitn    <= '0;
         shreg   <= '0;
         address <= '0;
         DO      <= 1'b0;
      end else begin
         state   <= state_nx;
         cyc     <= cyc_nx;
         bitn    <= bitn_nx;
         shreg   <= shreg_nx;
         address <= addr_nx;
         DO      <= do_nx;
      end
   end

   // Next state: gap timing, word load, bit timing and LED stepping
   always_comb begin
      state_nx = state;
      cyc_nx   = cyc;
      bitn_nx  = bitn;
      shreg_nx = shreg;
      addr_nx  = address;
      unique case (state)
         LATCHGAP: begin
            if (cyc == CW'(RST_CYC - 1)) begin
               cyc_nx   = '0;
               state_nx = LOAD;
            end else begin
               cyc_nx = cyc + 1'b1;
            end
         end
         LOAD: begin
            shreg_nx = {green_in, red_in, blue_in};
            bitn_nx  = 5'd23;
            cyc_nx   = '0;
            state_nx = SEND;
         end
         SEND: begin
            if (cyc == CW'(BIT_CYC - 1)) begin
               cyc_nx = '0;
               if (bitn == 5'd0) begin
                  if (address == AW'(NUM_LEDS - 1)) begin
                     addr_nx  = '0;
                     state_nx = LATCHGAP;
                  end else begin
                     addr_nx  = address + 1'b1;
                     state_nx = LOAD;
                  end
               end else begin
                  bitn_nx  = bitn - 1'b1;
                  shreg_nx = {shreg[22:0], 1'b0};
               end
            end else begin
               cyc_nx = cyc + 1'b1;
            end
         end
         default: begin
            cyc_nx   = '0;
            state_nx = LATCHGAP;
         end
      endcase
   end

   // Output: value DO takes next clock, so a bit's high phase starts
   // exactly on its first SEND cycle
   always_comb begin
      do_nx  = 1'b0;
      hi_cyc = shreg[23] ? CW'(T1H_CYC) : CW'(T0H_CYC);
      unique case (state)
         LOAD: do_nx = 1'b1;
         SEND: begin
            if (cyc == CW'(BIT_CYC - 1))
               do_nx = (bitn != 5'd0);
            else
               do_nx = (cyc + 1'b1) < hi_cyc;
         end
         default: do_nx = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_ws2811_driver.sv
// Scoreboard bench for ws2811_driver: expected pulses are queued by
// the stimulus and checked by a monitor that times every DO pulse.
module tb_ws2811_driver;

   localparam int N     = 8;
   localparam int SC    = 100000000;
   localparam int BIT   = 125;
   localparam int T0H   = 35;
   localparam int T1H   = 70;
   localparam int RST   = 5000;
   localparam int FRAME = 29008;

   typedef struct {
      int hi;
      int lo;
      int led;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [2:0] address;
   logic [7:0] red_in;
   logic [7:0] green_in;
   logic [7:0] blue_in;
   logic       DO;

   logic [7:0] r_tab [N];
   logic [7:0] g_tab [N];
   logic [7:0] b_tab [N];

   exp_t sb[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   prev_hi = -1;

   int    lo_cnt = 0;
   int    hi_cnt = 0;
   int    rise_lo = 0;
   int    rise_led = 0;
   bit    in_hi = 1'b0;
   time   last_rise = 0;
   bit    have_rise = 1'b0;

   assign red_in   = r_tab[address];
   assign green_in = g_tab[address];
   assign blue_in  = b_tab[address];

   ws2811_driver #(
      .NUM_LEDS(N),
      .SYSTEM_CLOCK(SC)
   ) dut (
      .clk(clk),
      .reset(reset),
      .address(address),
      .red_in(red_in),
      .green_in(green_in),
      .blue_in(blue_in),
      .DO(DO)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Queue the pulses of one whole frame from the current colour table
   task automatic push_frame();
      logic [23:0] w;
      exp_t e;
      for (int led = 0; led < N; led++) begin
         w = {g_tab[led], r_tab[led], b_tab[led]};
         for (int b = 23; b >= 0; b--) begin
            e.hi  = w[b] ? T1H : T0H;
            e.led = led;
            if (led == 0 && b == 23)
               e.lo = (prev_hi < 0) ? RST + 1 : BIT - prev_hi + RST + 1;
            else if (b == 23)
               e.lo = BIT - prev_hi + 1;
            else
               e.lo = BIT - prev_hi;
            sb.push_back(e);
            prev_hi = e.hi;
         end
      end
   endtask

   // Monitor: measure low-before and high length of each DO pulse
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset) begin
            chk("reset_do", int'(DO), 0);
            chk("reset_addr", int'(address), 0);
            lo_cnt    = 0;
            hi_cnt    = 0;
            in_hi     = 1'b0;
            have_rise = 1'b0;
         end else if (DO) begin
            if (!in_hi) begin
               in_hi    = 1'b1;
               hi_cnt   = 1;
               rise_lo  = lo_cnt;
               rise_led = int'(address);
               if (rise_lo > BIT) begin
                  if (have_rise)
                     chk("frame_period", int'(($time - last_rise) / 10), FRAME);
                  last_rise = $time;
                  have_rise = 1'b1;
               end
            end else begin
               hi_cnt++;
            end
         end else begin
            if (in_hi) begin
               in_hi = 1'b0;
               if (sb.size() == 0) begin
                  chk("sb_empty", 1, 0);
               end else begin
                  e = sb.pop_front();
                  chk("pulse_hi", hi_cnt, e.hi);
                  chk("pulse_lo", rise_lo, e.lo);
                  chk("pulse_led", rise_led, e.led);
               end
               lo_cnt = 1;
            end else begin
               lo_cnt++;
            end
         end
      end
   end

   task automatic wait_addr(input int a, input string nm);
      int k;
      k = 0;
      while (int'(address) != a && k < 40000) begin
         @(negedge clk);
         k++;
      end
      if (int'(address) != a)
         chk(nm, int'(address), a);
   endtask

   // Stimulus
   initial begin
      int k;
      r_tab[0] = 8'hFF;
      g_tab[0] = 8'hAA;
      b_tab[0] = 8'h00;
      for (int i = 1; i < N; i++) begin
         r_tab[i] = 8'(i);
         g_tab[i] = 8'(8'hC0 + i);
         b_tab[i] = 8'(8'h30 + 3 * i);
      end

      repeat (5) @(posedge clk);
      #1 reset = 1'b1;
      prev_hi = -1;
      push_frame();

      wait_addr(2, "wait_led2");
      repeat (500) @(negedge clk);
      g_tab[2] = 8'h0F;
      push_frame();

      wait_addr(0, "wait_wrap");
      chk("wrap_do_low", int'(DO), 0);
      wait_addr(4, "wait_led4");
      repeat (60) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("midreset_do", int'(DO), 0);
      chk("midreset_addr", int'(address), 0);
      sb.delete();
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      prev_hi = -1;
      push_frame();

      k = 0;
      while (sb.size() != 0 && k < 35000) begin
         @(negedge clk);
         k++;
      end
      chk("drain", sb.size(), 0);
      repeat (200) @(negedge clk);
      chk("gap_addr", int'(address), 0);
      chk("gap_do", int'(DO), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
